// File: rtl/shift_deserializer.sv
// shift_deserializer: LSB-first serial-to-parallel receiver with double-buffered valid/ready output
module shift_deserializer #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Shift_EN,
  input  logic          Shift_IN,
  input  logic          Clear,
  input  logic          Dout_Ready,
  output logic [N-1:0]  Dout,
  output logic          Dout_Valid,
  output logic          Overrun,
  output logic [CW-1:0] Bit_Count
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  sreg_q, sreg_d, dout_q, dout_d, word;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovr_q, ovr_d, shift, done;
  // Clear suppresses the sampled bit, so a word can never complete on a Clear edge
  assign shift = Shift_EN & ~Clear;
  assign done  = shift & (cnt_q == CW'(N - 1));
  assign word  = {Shift_IN, sreg_q[N-1:1]};
  // assembly path: shift register and bit counter
  always_comb begin
    sreg_d = Clear ? '0 : shift ? word : sreg_q;
    cnt_d  = Clear ? '0 : shift ? (done ? '0 : cnt_q + CW'(1)) : cnt_q;
  end
  // holding register FSM: a completing word is taken when empty or when the held word leaves on the same edge
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    ovr_d   = Clear ? 1'b0 : ovr_q;
    if (state_q == EMPTY) begin
      if (done) begin
        dout_d  = word;
        state_d = FULL;
      end
    end else if (done) begin
      dout_d = Dout_Ready ? word : dout_q;
      ovr_d  = Dout_Ready ? ovr_d : 1'b1;
    end else if (Dout_Ready) begin
      state_d = EMPTY;
    end
  end
  // state registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= EMPTY;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ovr_q   <= ovr_d;
    end
  end
  assign Dout       = dout_q;
  assign Dout_Valid = (state_q == FULL);
  assign Overrun    = ovr_q;
  assign Bit_Count  = cnt_q;
endmodule

// File: tb/tb_shift_deserializer.sv
// tb_shift_deserializer: directed and random stimulus against a queue-based reference model with scoreboard
module tb_shift_deserializer;
  localparam int N  = 8;
  localparam int CW = $clog2(N);
  logic clk = 0, rst = 1, sen = 0, sin = 0, clr = 0, rdy = 0;
  logic [N-1:0]  dout;
  logic          valid, ovr;
  logic [CW-1:0] cnt;
  int n_chk = 0, n_fail = 0;
  bit          bq[$];
  logic [N-1:0] exp_q[$];
  logic [N-1:0] m_dout = 0, w;
  bit          m_full = 0, m_ovr = 0;
  shift_deserializer #(.N(N)) dut (
    .Clk(clk), .Reset(rst), .Shift_EN(sen), .Shift_IN(sin), .Clear(clr),
    .Dout_Ready(rdy), .Dout(dout), .Dout_Valid(valid), .Overrun(ovr), .Bit_Count(cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: collect bits in a queue, build the word arithmetically on the Nth bit
  always @(posedge clk) begin
    if (rst) begin
      bq.delete();
      exp_q.delete();
      m_full = 0;
      m_ovr  = 0;
      m_dout = 0;
    end else begin
      if (m_full && rdy) m_full = 0;
      if (clr) begin
        bq.delete();
        m_ovr = 0;
      end else if (sen) begin
        bq.push_back(sin);
        if (bq.size() == N) begin
          w = 0;
          for (int i = 0; i < N; i++) w = w + (N'(bq[i]) << i);
          bq.delete();
          if (!m_full) begin
            m_full = 1;
            m_dout = w;
            exp_q.push_back(w);
          end else m_ovr = 1;
        end
      end
    end
  end
  // scoreboard monitor: compares state every cycle, pops the expected word on each handshake
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", 32'(valid), 32'(m_full));
      chk("bit_count", 32'(cnt), 32'(bq.size()));
      chk("overrun", 32'(ovr), 32'(m_ovr));
      chk("dout_hold", 32'(dout), 32'(m_dout));
      if (valid && rdy) begin
        if (exp_q.size() == 0) chk("scoreboard_empty", 32'(1), 32'(0));
        else chk("handshake_word", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end
  task automatic cyc(input bit s, input bit d, input bit c, input bit r);
    sen = s; sin = d; clr = c; rdy = r;
    @(posedge clk);
    #1;
    sen = 0; clr = 0; rdy = 0;
  endtask
  task automatic send(input logic [N-1:0] v, input int max_gap, input bit rdy_last);
    for (int i = 0; i < N; i++) begin
      int g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int k = 0; k < g; k++) cyc(0, 0, 0, 0);
      cyc(1, v[i], 0, (i == N - 1) && rdy_last);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_dout", 32'(dout), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_count", 32'(cnt), 0);
    chk("reset_overrun", 32'(ovr), 0);
    send(8'hA5, 0, 0);
    chk("a5_dout", 32'(dout), 32'h A5);
    chk("a5_valid", 32'(valid), 1);
    chk("a5_count", 32'(cnt), 0);
    cyc(0, 0, 0, 1);
    chk("a5_consumed", 32'(valid), 0);
    send(8'hA5, 3, 0);
    chk("a5_gap_dout", 32'(dout), 32'h A5);
    cyc(0, 0, 0, 1);
    chk("a5_gap_consumed", 32'(valid), 0);
    send(8'h3C, 0, 0);
    send(8'hC3, 0, 1);
    chk("b2b_dout", 32'(dout), 32'h C3);
    chk("b2b_valid", 32'(valid), 1);
    chk("b2b_overrun", 32'(ovr), 0);
    cyc(0, 0, 0, 1);
    send(8'h3C, 0, 0);
    send(8'hFF, 0, 0);
    chk("ovr_dout", 32'(dout), 32'h 3C);
    chk("ovr_set", 32'(ovr), 1);
    cyc(0, 0, 1, 0);
    chk("clr_overrun", 32'(ovr), 0);
    chk("clr_valid", 32'(valid), 1);
    chk("clr_dout", 32'(dout), 32'h 3C);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 1'((8'h0F >> i) & 1), 0, 0);
    cyc(1, 0, 1, 0);
    chk("clr_shift_count", 32'(cnt), 0);
    send(8'h81, 0, 0);
    chk("after_clr_dout", 32'(dout), 32'h 81);
    cyc(0, 0, 0, 1);
    send(8'h55, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
    rst = 1;
    cyc(0, 0, 0, 0);
    rst = 0;
    chk("rst_full_dout", 32'(dout), 0);
    chk("rst_full_valid", 32'(valid), 0);
    chk("rst_full_count", 32'(cnt), 0);
    chk("rst_full_overrun", 32'(ovr), 0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(299, 0) == 0);
      cyc($urandom_range(1, 0) == 1, 1'($urandom), $urandom_range(39, 0) == 0,
          $urandom_range(9, 0) < 3);
      rst = 0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Receive-side counterpart of the team's N-bit right-shift transmit register.
- Consumes the serial stream that register emits: LSB first, one bit per cycle in which Shift_EN is high.
- Reassembles each N-bit word and presents it on a double-buffered parallel output with a valid/ready handshake.
- Sits between a serial link and a parallel consumer such as the multiplier datapath or the display logic.

Parameters:
- N, 8, word width in bits; legal range N >= 2.
- CW, $clog2(N), width of the bit counter and the Bit_Count port.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Shift_EN  input  1  qualifies Shift_IN; one bit is sampled per rising edge in which it is high.
- Shift_IN  input  1  serial data, LSB of the word first.
- Clear  input  1  synchronous abort: discards the partially assembled word and clears Overrun.
- Dout_Ready  input  1  consumer accepts Dout when high together with Dout_Valid.
- Dout  output  N  most recently completed word (holding register).
- Dout_Valid  output  1  Dout holds an unconsumed word.
- Overrun  output  1  sticky flag: a completed word was dropped because the holding register was full.
- Bit_Count  output  CW  number of bits of the current partial word already sampled (0..N-1).

Behaviour:
- Reset values: Dout=0, Dout_Valid=0, Overrun=0, Bit_Count=0, internal shift register=0, FSM=EMPTY.
- Reset takes priority over every other input, including mid-word and with Dout_Valid high. Any partial word and any held word are lost.
- Shifting: on an edge with Shift_EN=1 and Clear=0, sreg <= {Shift_IN, sreg[N-1:1]}.
  - If Bit_Count < N-1: Bit_Count increments.
  - If Bit_Count == N-1: word completion. The completed word W = {Shift_IN, sreg[N-1:1]}, and Bit_Count wraps to 0.
- Bit ordering: W[0] is the first bit received and W[N-1] the last. Shifting a word out of the transmit register reproduces it here unchanged.
- Shift_EN=0: sreg and Bit_Count hold. Gaps of any length between bits are legal.
- Output FSM, two states: EMPTY (Dout_Valid=0) and FULL (Dout_Valid=1). Dout_Valid is a registered decode of the state.
  - EMPTY, completion: Dout <= W; go to FULL. Dout_Valid is high in the cycle after the edge that sampled the Nth bit (zero added latency).
  - FULL, Dout_Ready=1, no completion: go to EMPTY. Dout holds its last value.
  - FULL, Dout_Ready=1, completion on the same edge: Dout <= W; stay FULL. Dout_Valid stays high and no word is lost.
  - FULL, Dout_Ready=0, completion: W is discarded; Dout is unchanged; Overrun <= 1; stay FULL.
  - FULL, Dout_Ready=0, no completion: hold.
- Dout_Ready is ignored in EMPTY.
- Dout and Dout_Valid are stable while Dout_Valid=1 and Dout_Ready=0.
- Clear:
  - sreg <= 0, Bit_Count <= 0, Overrun <= 0.
  - Dout and Dout_Valid are not affected.
  - Clear with Shift_EN in the same cycle: Clear wins; that bit is dropped and no completion occurs.
  - Clear with Dout_Ready in FULL: the handshake completes normally and the FSM goes to EMPTY.
- Overrun is set only by the dropped-word case. It is cleared only by Reset or Clear. Set has priority over Clear only if both occur on the same edge — which cannot happen, because Clear suppresses completion.
- Bit_Count is a registered output and is always < N.

Test Plan:
- Reset, then 8 shift cycles with bits 1,0,1,0,0,1,0,1 (0xA5 LSB first), Dout_Ready=0 -> after the 8th edge: Dout=0xA5, Dout_Valid=1, Bit_Count=0, Overrun=0.
- Same 0xA5 stream with 0-3 idle cycles (Shift_EN=0) inserted randomly between bits, then Dout_Ready=1 for one cycle -> Dout=0xA5; Dout_Valid falls the next cycle; Bit_Count holds through every idle cycle.
- Back-to-back 0x3C then 0xC3, with Dout_Ready=1 exactly on the edge completing 0xC3 -> Dout goes 0x3C to 0xC3, Dout_Valid stays high throughout, Overrun=0.
- 0x3C held with Dout_Ready=0, then 0xFF fully shifted -> Dout stays 0x3C, Overrun=1. Then assert Clear -> Overrun=0, Dout_Valid still 1, Dout=0x3C.
- Shift in 5 bits of 0x0F, assert Clear together with a 6th Shift_EN -> Bit_Count=0. A fresh 8-bit stream of 0x81 then yields Dout=0x81.
- Shift in 3 bits, then Reset while FULL with 0x55 held -> Dout=0, Dout_Valid=0, Bit_Count=0, Overrun=0 on the next cycle.
